// File: rtl/phy_rx_pkg.sv
// Shared types and defaults for the multi-lane serial-to-parallel receiver.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } lane_state_e;

  localparam int         DEF_WIDTH = 8;
  localparam logic [7:0] DEF_COMMA = 8'hBC;

endpackage

// File: rtl/phy_rx_s2p_lane.sv
// One receive lane: shift register, comma search/alignment FSM and symbol capture.
//   state  | meaning
//   SEARCH | hunting for COMMA at every bit offset
//   ALIGN  | comma found, counting consecutive aligned commas
//   LOCKED | symbol-aligned; non-comma symbols are presented on data/valid
module phy_rx_s2p_lane
  import phy_rx_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 0
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             active
);

  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int GW  = $clog2(MAX_GAP + 2);

  lane_state_e      state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, data_nxt, sym;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [LCW-1:0]   comma_cnt, comma_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
  logic             valid_nxt, boundary, is_comma;

  assign sym      = {shreg[WIDTH-2:0], in};
  assign is_comma = (sym == COMMA);
  assign boundary = (bit_cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    data_nxt      = data;
    valid_nxt     = valid;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    gap_cnt_nxt   = gap_cnt;
    if (!enable) begin
      state_nxt     = SEARCH;
      bit_cnt_nxt   = '0;
      comma_cnt_nxt = '0;
      gap_cnt_nxt   = '0;
      valid_nxt     = 1'b0;
    end else begin
      shreg_nxt   = sym;
      bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
      case (state)
        SEARCH: begin
          // The comma's last bit sets the phase: the next boundary is WIDTH edges later.
          bit_cnt_nxt = '0;
          if (is_comma) begin
            state_nxt     = (LOCK_COUNT <= 1) ? LOCKED : ALIGN;
            comma_cnt_nxt = LCW'(1);
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_nxt = comma_cnt + 1'b1;
              if (comma_cnt_nxt == LCW'(LOCK_COUNT)) state_nxt = LOCKED;
            end else begin
              state_nxt     = SEARCH;
              comma_cnt_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (is_comma) begin
              valid_nxt   = 1'b0;
              gap_cnt_nxt = '0;
            end else if (MAX_GAP > 0 && gap_cnt == GW'(MAX_GAP)) begin
              // Too long without a comma: drop this symbol and re-acquire.
              state_nxt     = SEARCH;
              valid_nxt     = 1'b0;
              comma_cnt_nxt = '0;
              gap_cnt_nxt   = '0;
            end else begin
              data_nxt    = sym;
              valid_nxt   = 1'b1;
              gap_cnt_nxt = gap_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
    end
  end

  assign active = (state == LOCKED);

endmodule

// File: rtl/phy_rx_s2p_n.sv
// Multi-lane serial-to-parallel receiver; lanes align and lock independently.
module phy_rx_s2p_n
  import phy_rx_pkg::*;
#(
  parameter int               LANES      = 2,
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 0
) (
  input  logic                   clk_8f,
  input  logic                   reset_L,
  input  logic                   enable,
  input  logic [LANES-1:0]       in,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES-1:0]       active,
  output logic                   all_active
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_rx_s2p_lane #(
      .WIDTH      (WIDTH),
      .COMMA      (COMMA),
      .LOCK_COUNT (LOCK_COUNT),
      .MAX_GAP    (MAX_GAP)
    ) u_lane (
      .clk_8f  (clk_8f),
      .reset_L (reset_L),
      .enable  (enable),
      .in      (in[i]),
      .data    (data_out[i*WIDTH +: WIDTH]),
      .valid   (valid_out[i]),
      .active  (active[i])
    );
  end

  assign all_active = &active;

endmodule
